conv1_relu_maxpool: RTL and testbench
=====================================

Name: conv1_relu_maxpool

Overview:
- Sits directly downstream of the conv1 convolution stage and consumes its three 12-bit signed per-channel results plus the valid strobe.
- Applies ReLU, then 2x2 stride-2 max pooling on each channel's 24x24 raster-order stream, producing a 12x12 map per channel.
- Buffers half a row of horizontal-pair maxima per channel so that each pooled output is emitted as soon as the bottom-right pixel of its window arrives.
- Feeds the next convolution stage's line buffer.

Parameters:
- WIDTH, 24, conv output row length in pixels; must be even.
- HEIGHT, 24, conv output rows per frame; must be even.
- DATA_BITS, 12, signed width of each channel sample in and out.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  conv result valid; one pixel per high cycle, gaps allowed.
- conv_out_1  in  DATA_BITS  channel 1 conv result, signed.
- conv_out_2  in  DATA_BITS  channel 2 conv result, signed.
- conv_out_3  in  DATA_BITS  channel 3 conv result, signed.
- pool_out_1  out  DATA_BITS  channel 1 pooled result, signed, always >= 0.
- pool_out_2  out  DATA_BITS  channel 2 pooled result.
- pool_out_3  out  DATA_BITS  channel 3 pooled result.
- valid_out_pool  out  1  one-cycle pulse marking pool_out_* valid.

Behaviour:
- Reset (async, rst_n=0):
  - col_cnt, row_cnt, pair hold registers, all outputs and valid_out_pool go to 0.
  - Line-buffer contents are don't-care; they are never read before being written in the current frame.
- ReLU: r = (x[DATA_BITS-1]) ? 0 : x, per channel, applied to every accepted sample.
- Counters advance only when valid_in=1.
  - col_cnt runs 0..WIDTH-1, then wraps to 0 and increments row_cnt.
  - row_cnt runs 0..HEIGHT-1, then wraps to 0. The next frame starts immediately; there is no idle state.
- Cycles with valid_in=0 hold all state. valid_out_pool=0 in those cycles.
- Per channel, each accepted sample is processed by position:
  - Even col: hold <= r.
  - Odd col: pmax = max(hold, r), signed compare.
    - Even row: linebuf[col_cnt>>1] <= pmax.
    - Odd row: pool_out <= max(linebuf[col_cnt>>1], pmax); valid_out_pool <= 1 on the next edge.
- Latency: exactly 1 cycle from the valid_in cycle carrying the (odd row, odd col) pixel to the valid_out_pool pulse.
- Output count: (WIDTH/2)*(HEIGHT/2) = 144 pulses per frame, in raster order.
- Register behaviour:
  - pool_out_* hold their last value while valid_out_pool=0.
  - valid_out_pool is registered and deasserts the cycle after a pulse unless another qualifying pixel arrived.
- Storage: linebuf is WIDTH/2 entries x DATA_BITS per channel, 3 arrays total. Registers or distributed RAM with 1-cycle write and combinational read.
- Widths: no arithmetic growth, since max and ReLU are width-preserving. Output MSB is always 0.
- Back-to-back frames: the last pixel (row HEIGHT-1, col WIDTH-1) emits the final pool output and wraps both counters in the same cycle. The next frame's first pixel may arrive on the following cycle.
- Reset mid-frame: counters return to 0 asynchronously and any partial window is discarded. The first pixel after reset release is treated as (row 0, col 0).
- All three channels share the counters and valid; they are always processed in lockstep.

Test Plan:
- Ramp: channel 1 pixel value = row*24+col (all positive), valid_in held high for one frame.
  -> 144 pulses; first pool_out_1 = 25 (pixel (1,1)), last = 575, output k = 48*(k/12) + 2*(k%12) + 25.
- All-negative: channel 2 = -100 everywhere, channel 3 = -2048 everywhere.
  -> every pool_out_2 = 0 and pool_out_3 = 0.
- Mixed window: window values {-5, 7, 2047, 3} on channel 1.
  -> pool_out_1 = 2047; with {-1, -1, -1, 0} -> 0.
- Valid gaps: same ramp with valid_in toggled in a 1-on/2-off pattern.
  -> identical 144-value sequence; each pulse exactly 1 cycle after its qualifying input.
  - Independently check that pool_out_* hold their values between pulses.
- Back-to-back frames: two ramp frames with no gap.
  -> 288 pulses; the second frame's first output = 25, with no corruption from frame-1 linebuf data.
- Reset mid-frame: assert rst_n=0 asynchronously at row 7, col 10, for 3 cycles.
  -> outputs and valid_out_pool are 0 immediately; a fresh ramp frame then yields the exact ramp results.

Source files
------------

// File: rtl/conv1_relu_maxpool.sv
// conv1_relu_maxpool
//   ReLU followed by 2x2 stride-2 max pooling on three lockstep channels of a
//   raster-order conv result stream. The max of each horizontal pixel pair on
//   an even row is kept in a half-row line buffer. On the odd row below it, the
//   window max is emitted one cycle after the window's bottom-right pixel.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   valid_in       one accepted pixel per high cycle; gaps allowed
//   conv_out_1..3  signed per-channel conv results
//   pool_out_1..3  pooled results (never negative); held between pulses
//   valid_out_pool one-cycle pulse marking pool_out_* valid
module conv1_relu_maxpool #(
    parameter int WIDTH     = 24,
    parameter int HEIGHT    = 24,
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] conv_out_1,
    input  logic [DATA_BITS-1:0] conv_out_2,
    input  logic [DATA_BITS-1:0] conv_out_3,
    output logic [DATA_BITS-1:0] pool_out_1,
    output logic [DATA_BITS-1:0] pool_out_2,
    output logic [DATA_BITS-1:0] pool_out_3,
    output logic                 valid_out_pool
);

    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int HALF  = WIDTH / 2;
    localparam int NCH   = 3;

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-2:0] lb_idx;
    logic             col_last;
    logic             row_last;
    logic             odd_col;
    logic             odd_row;

    logic signed [DATA_BITS-1:0] din     [NCH];
    logic signed [DATA_BITS-1:0] relu_v  [NCH];
    logic signed [DATA_BITS-1:0] hold    [NCH];
    logic signed [DATA_BITS-1:0] pmax    [NCH];
    logic signed [DATA_BITS-1:0] lb_rd   [NCH];
    logic signed [DATA_BITS-1:0] wmax    [NCH];
    logic signed [DATA_BITS-1:0] pool_q  [NCH];
    logic signed [DATA_BITS-1:0] linebuf [NCH][HALF];

    function automatic logic signed [DATA_BITS-1:0] smax(
        input logic signed [DATA_BITS-1:0] a,
        input logic signed [DATA_BITS-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign din[0] = conv_out_1;
    assign din[1] = conv_out_2;
    assign din[2] = conv_out_3;

    // Pixel pair (2k, 2k+1) maps to line-buffer slot k.
    assign lb_idx   = col_cnt[COL_W-1:1];
    assign odd_col  = col_cnt[0];
    assign odd_row  = row_cnt[0];
    assign col_last = (col_cnt == COL_W'(WIDTH - 1));
    assign row_last = (row_cnt == ROW_W'(HEIGHT - 1));

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            relu_v[i] = din[i][DATA_BITS-1] ? '0 : din[i];
            pmax[i]   = smax(hold[i], relu_v[i]);
            lb_rd[i]  = linebuf[i][lb_idx];
            wmax[i]   = smax(lb_rd[i], pmax[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt        <= '0;
            row_cnt        <= '0;
            valid_out_pool <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                hold[i]   <= '0;
                pool_q[i] <= '0;
            end
        end else begin
            valid_out_pool <= valid_in && odd_col && odd_row;
            if (valid_in) begin
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
                for (int i = 0; i < NCH; i++) begin
                    if (!odd_col) begin
                        hold[i] <= relu_v[i];
                    end else if (odd_row) begin
                        pool_q[i] <= wmax[i];
                    end
                end
            end
        end
    end

    // Line buffer needs no reset: every slot is written on an even row before
    // the odd row below it reads it.
    always_ff @(posedge clk) begin
        if (valid_in && odd_col && !odd_row) begin
            for (int i = 0; i < NCH; i++) begin
                linebuf[i][lb_idx] <= pmax[i];
            end
        end
    end

    assign pool_out_1 = pool_q[0];
    assign pool_out_2 = pool_q[1];
    assign pool_out_3 = pool_q[2];

endmodule

// File: tb/tb_conv1_relu_maxpool.sv
module tb_conv1_relu_maxpool;

    localparam int W  = 24;
    localparam int H  = 24;
    localparam int DB = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [DB-1:0] conv_out_1, conv_out_2, conv_out_3;
    logic [DB-1:0] pool_out_1, pool_out_2, pool_out_3;
    logic          valid_out_pool;

    conv1_relu_maxpool #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .conv_out_1     (conv_out_1),
        .conv_out_2     (conv_out_2),
        .conv_out_3     (conv_out_3),
        .pool_out_1     (pool_out_1),
        .pool_out_2     (pool_out_2),
        .pool_out_3     (pool_out_3),
        .valid_out_pool (valid_out_pool)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int img  [3][H][W];
    int expv [3][H/2][W/2];
    int last_out [3];
    int cap [$];
    int pulses;

    task automatic chk(input string tag, input int got, input int exp_v);
        checks++;
        assert (got === exp_v) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp_v);
        end
    endtask

    // Pooled map straight from the definition: max of the ReLU'd window,
    // i.e. max of zero and the four raw samples.
    task automatic compute_exp();
        for (int ch = 0; ch < 3; ch++)
            for (int pr = 0; pr < H/2; pr++)
                for (int pc = 0; pc < W/2; pc++) begin
                    int m = 0;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++)
                            if (img[ch][2*pr+dy][2*pc+dx] > m) m = img[ch][2*pr+dy][2*pc+dx];
                    expv[ch][pr][pc] = m;
                end
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[0][r][c] = r * W + c;
                img[1][r][c] = -100;
                img[2][r][c] = -2048;
            end
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[ch][r][c] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    task automatic check_hold();
        chk("hold_1", int'(pool_out_1), last_out[0]);
        chk("hold_2", int'(pool_out_2), last_out[1]);
        chk("hold_3", int'(pool_out_3), last_out[2]);
    endtask

    task automatic step_idle();
        valid_in   = 1'b0;
        conv_out_1 = DB'($urandom);
        conv_out_2 = DB'($urandom);
        conv_out_3 = DB'($urandom);
        @(posedge clk); #1;
        chk("valid_idle", int'(valid_out_pool), 0);
        check_hold();
    endtask

    task automatic step_pix(input int r, input int c);
        bit qual;
        valid_in   = 1'b1;
        conv_out_1 = DB'(img[0][r][c]);
        conv_out_2 = DB'(img[1][r][c]);
        conv_out_3 = DB'(img[2][r][c]);
        qual = (r % 2 == 1) && (c % 2 == 1);
        @(posedge clk); #1;
        chk("valid_pix", int'(valid_out_pool), int'(qual));
        if (qual) begin
            chk("pool_1", int'(pool_out_1), expv[0][r/2][c/2]);
            chk("pool_2", int'(pool_out_2), expv[1][r/2][c/2]);
            chk("pool_3", int'(pool_out_3), expv[2][r/2][c/2]);
            for (int k = 0; k < 3; k++) last_out[k] = expv[k][r/2][c/2];
            cap.push_back(int'(pool_out_1));
            pulses++;
        end else begin
            check_hold();
        end
    endtask

    // gap >= 0: fixed idle cycles before each pixel; gap < 0: random 0..2.
    // stop_idx < W*H aborts the frame after that raster index.
    task automatic run_frame(input int gap, input int stop_idx);
        compute_exp();
        cap.delete();
        pulses = 0;
        for (int p = 0; p < W * H; p++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) step_idle();
            step_pix(p / W, p % W);
            if (p == stop_idx) return;
        end
        chk("pulse_count", pulses, (W/2) * (H/2));
    endtask

    task automatic check_ramp_formula(input string tag);
        chk({tag, "_count"}, cap.size(), 144);
        if (cap.size() == 144) begin
            chk({tag, "_first"}, cap[0], 25);
            chk({tag, "_last"}, cap[143], 575);
            for (int k = 0; k < 144; k++)
                chk({tag, "_seq"}, cap[k], 48 * (k / 12) + 2 * (k % 12) + 25);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        conv_out_1 = '0;
        conv_out_2 = '0;
        conv_out_3 = '0;
        for (int k = 0; k < 3; k++) last_out[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid_out_pool), 0);
        check_hold();
        rst_n = 1'b1;

        // Ramp on ch1, negative constants on ch2/ch3.
        fill_ramp();
        run_frame(0, W * H);
        check_ramp_formula("ramp");

        // Same ramp with 1-on/2-off valid pattern.
        run_frame(2, W * H);
        check_ramp_formula("gaps");

        // Two back-to-back frames, no idle between them.
        run_frame(0, W * H);
        check_ramp_formula("b2b_a");
        run_frame(0, W * H);
        check_ramp_formula("b2b_b");

        // Random data with two hand-placed windows.
        fill_random();
        img[0][0][0] = -5;  img[0][0][1] = 7;  img[0][1][0] = 2047; img[0][1][1] = 3;
        img[0][0][2] = -1;  img[0][0][3] = -1; img[0][1][2] = -1;   img[0][1][3] = 0;
        run_frame(0, W * H);
        chk("mixed_count", cap.size(), 144);
        if (cap.size() >= 2) begin
            chk("mixed_win0", cap[0], 2047);
            chk("mixed_win1", cap[1], 0);
        end

        // Random data with random gaps.
        fill_random();
        run_frame(-1, W * H);

        // Partial ramp, async reset at row 7 col 10, then a clean ramp frame.
        fill_ramp();
        run_frame(0, 7 * W + 10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(valid_out_pool), 0);
        chk("midrst_p1", int'(pool_out_1), 0);
        chk("midrst_p2", int'(pool_out_2), 0);
        chk("midrst_p3", int'(pool_out_3), 0);
        for (int k = 0; k < 3; k++) last_out[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(0, W * H);
        check_ramp_formula("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
